// File: rtl/ballot_controller_if.sv
// Candidate-side and display-side signal bundle for ballot_controller.
// The master drives officer/voter inputs; the slave (controller) drives feedback and results.
interface ballot_controller_if #(
    parameter int unsigned NUM_CAND = 4,
    parameter int unsigned COUNT_W  = 8
);
    localparam int unsigned IDX_W = $clog2(NUM_CAND);

    logic                mode;
    logic                arm;
    logic [NUM_CAND-1:0] button;
    logic [COUNT_W-1:0]  led;
    logic                ready;
    logic                vote_accepted;
    logic [IDX_W-1:0]    winner_idx;
    logic                tie;
    logic                overflow;

    modport master (
        output mode, arm, button,
        input  led, ready, vote_accepted, winner_idx, tie, overflow
    );

    modport slave (
        input  mode, arm, button,
        output led, ready, vote_accepted, winner_idx, tie, overflow
    );
endinterface

// File: rtl/ballot_controller.sv
// One-ballot-per-arm voting controller: debounced single-button vote capture,
// saturating per-candidate tallies, acknowledgement feedback and leader tracking.
module ballot_controller #(
    parameter int unsigned NUM_CAND        = 4,
    parameter int unsigned COUNT_W         = 8,
    parameter int unsigned HOLD_CYCLES     = 100000000,
    parameter int unsigned FEEDBACK_CYCLES = 100000000
) (
    input logic          clock,
    input logic          reset_n,
    ballot_controller_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_CAND);
    localparam int unsigned HW    = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned FW    = $clog2(FEEDBACK_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [FW-1:0] FB_LAST  = FW'(FEEDBACK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ARMED, FEEDBACK, RELEASE} state_t;

    state_t              state_q, state_d;
    logic [HW-1:0]       hold_q, hold_d, hold_inc;
    logic [FW-1:0]       fb_q, fb_d;
    logic [NUM_CAND-1:0] sel_q;
    logic [COUNT_W-1:0]  cnt_q [NUM_CAND];
    logic [COUNT_W-1:0]  cnt_d [NUM_CAND];
    logic [COUNT_W-1:0]  led_q, led_d;
    logic [COUNT_W-1:0]  max_v;
    logic [IDX_W-1:0]    win_q, win_d;
    logic                acc_q, acc_d, ovf_q, ovf_d, tie_q, tie_d;
    logic                single, detect, found;

    assign single = (bus.button != '0) && ((bus.button & (bus.button - NUM_CAND'(1))) == '0);

    always_comb begin
        state_d  = state_q;
        hold_inc = '0;
        hold_d   = '0;
        fb_d     = '0;
        detect   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.arm && !bus.mode) state_d = ARMED;
            end
            ARMED: begin
                if (bus.mode) begin
                    state_d = IDLE;
                end else if (single) begin
                    // A run continues only while the same single button stays down.
                    hold_inc = (hold_q != '0 && bus.button == sel_q) ? hold_q + HW'(1) : HW'(1);
                    if (hold_inc == HOLD_MAX) begin
                        detect  = 1'b1;
                        state_d = FEEDBACK;
                    end else begin
                        hold_d = hold_inc;
                    end
                end
            end
            FEEDBACK: begin
                if (fb_q == FB_LAST) state_d = RELEASE;
                else                 fb_d    = fb_q + FW'(1);
            end
            RELEASE: begin
                if (bus.button == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        acc_d = detect;
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            if (detect && bus.button[i]) begin
                if (cnt_q[i] == '1) ovf_d    = 1'b1;
                else                cnt_d[i] = cnt_q[i] + COUNT_W'(1);
            end
        end
    end

    always_comb begin
        led_d = '0;
        found = 1'b0;
        if (state_d == FEEDBACK && !bus.mode) begin
            led_d = '1;
        end else if (bus.mode) begin
            for (int unsigned i = 0; i < NUM_CAND; i++) begin
                if (!found && bus.button[i]) begin
                    led_d = cnt_q[i];
                    found = 1'b1;
                end
            end
        end
    end

    // Strict '>' keeps the lowest index on equal counts.
    always_comb begin
        max_v = cnt_q[0];
        win_d = '0;
        tie_d = 1'b0;
        for (int unsigned i = 1; i < NUM_CAND; i++) begin
            if (cnt_q[i] > max_v) begin
                max_v = cnt_q[i];
                win_d = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            if (cnt_q[i] == max_v && IDX_W'(i) != win_d && max_v != '0) tie_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            fb_q    <= '0;
            sel_q   <= '0;
            for (int unsigned i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
            led_q   <= '0;
            acc_q   <= 1'b0;
            ovf_q   <= 1'b0;
            win_q   <= '0;
            tie_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            fb_q    <= fb_d;
            sel_q   <= bus.button;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            win_q   <= win_d;
            tie_q   <= tie_d;
        end
    end

    assign bus.led           = led_q;
    assign bus.ready         = (state_q == ARMED);
    assign bus.vote_accepted = acc_q;
    assign bus.winner_idx    = win_q;
    assign bus.tie           = tie_q;
    assign bus.overflow      = ovf_q;
endmodule

// File: tb/tb_ballot_controller.sv
// Self-checking bench for ballot_controller: a ballot-level reference model compared
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_ballot_controller;
    localparam int unsigned NC   = 4;
    localparam int unsigned CW   = 3;
    localparam int unsigned HOLD = 4;
    localparam int unsigned FB   = 3;
    localparam int          CMAX = (1 << CW) - 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    ballot_controller_if #(.NUM_CAND(NC), .COUNT_W(CW)) bus ();

    ballot_controller #(
        .NUM_CAND(NC),
        .COUNT_W(CW),
        .HOLD_CYCLES(HOLD),
        .FEEDBACK_CYCLES(FB)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;
    int acc_seen = 0;
    int full_led_seen = 0;

    // Reference model: ballot-level bookkeeping, expected outputs after the next edge.
    int          m_cnt [NC];
    bit          m_open, m_rel, m_acc, m_ovf, m_tie;
    int          m_press, m_fb, m_led, m_win;
    logic [NC-1:0] m_last;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    endtask

    task automatic model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_open = 0; m_rel = 0; m_acc = 0; m_ovf = 0; m_tie = 0;
        m_press = 0; m_fb = 0; m_led = 0; m_win = 0; m_last = '0;
    endtask

    // Called between edges with the inputs the next rising edge will sample.
    task automatic model_step();
        int old [NC];
        int mx, nmax, k;
        old = m_cnt;
        mx = 0; m_win = 0; nmax = 0;
        for (int i = 0; i < NC; i++) if (old[i] > mx) begin mx = old[i]; m_win = i; end
        for (int i = 0; i < NC; i++) if (old[i] == mx) nmax++;
        m_tie = (mx > 0) && (nmax > 1);
        m_acc = 0;
        if (m_open) begin
            if (bus.mode) begin
                m_open = 0; m_press = 0;
            end else if ($countones(bus.button) == 1) begin
                m_press = (m_press > 0 && bus.button == m_last) ? m_press + 1 : 1;
                if (m_press == HOLD) begin
                    k = 0;
                    for (int i = 0; i < NC; i++) if (bus.button[i]) k = i;
                    if (m_cnt[k] == CMAX) m_ovf = 1;
                    else m_cnt[k] = m_cnt[k] + 1;
                    m_acc = 1; m_open = 0; m_press = 0; m_fb = FB;
                end
            end else begin
                m_press = 0;
            end
        end else if (m_fb > 0) begin
            m_fb = m_fb - 1;
            if (m_fb == 0) m_rel = 1;
        end else if (m_rel) begin
            if (bus.button == '0) m_rel = 0;
        end else if (bus.arm && !bus.mode) begin
            m_open = 1;
        end
        m_last = bus.button;
        if (m_fb > 0 && !bus.mode) m_led = CMAX;
        else if (bus.mode) begin
            m_led = 0;
            for (int i = NC - 1; i >= 0; i--) if (bus.button[i]) m_led = old[i];
        end else m_led = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clock);
            if (!reset_n) model_reset();
            check("led",           int'(bus.led),           m_led);
            check("ready",         int'(bus.ready),         int'(m_open));
            check("vote_accepted", int'(bus.vote_accepted), int'(m_acc));
            check("winner_idx",    int'(bus.winner_idx),    m_win);
            check("tie",           int'(bus.tie),           int'(m_tie));
            check("overflow",      int'(bus.overflow),      int'(m_ovf));
            if (bus.vote_accepted) acc_seen++;
            if (int'(bus.led) == CMAX) full_led_seen++;
            if (reset_n) model_step();
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic vote(input int k);
        bus.arm = 1'b1;
        cyc(1);
        bus.arm = 1'b0;
        bus.button = NC'(1 << k);
        cyc(HOLD);
        cyc(FB);
        bus.button = '0;
        cyc(2);
    endtask

    int a0;

    initial begin
        bus.mode = 1'b0; bus.arm = 1'b0; bus.button = '0;
        #3;
        check("rst_led",   int'(bus.led),           0);
        check("rst_ready", int'(bus.ready),         0);
        check("rst_acc",   int'(bus.vote_accepted), 0);

        // First arm after reset release is taken on the first edge.
        @(posedge clock); #1;
        bus.arm = 1'b1;
        reset_n = 1'b1;
        cyc(1);
        check("first_arm_ready", int'(bus.ready), 1);
        bus.arm = 1'b0;
        bus.button = 4'b0001;
        cyc(HOLD);
        check("v0_pulse", int'(bus.vote_accepted), 1);
        cyc(FB);
        bus.button = '0;
        cyc(2);
        check("v0_pulses",   acc_seen, 1);
        check("v0_led_full", full_led_seen, 3);
        check("v0_model_c0", m_cnt[0], 1);
        check("v0_winner",   int'(bus.winner_idx), 0);
        check("v0_tie",      int'(bus.tie), 0);

        // No arm: holding a button does nothing.
        a0 = acc_seen;
        bus.button = 4'b0010;
        cyc(10);
        check("noarm_ready", int'(bus.ready), 0);
        bus.button = '0;
        cyc(1);
        check("noarm_pulses",   acc_seen - a0, 0);
        check("noarm_model_c1", m_cnt[1], 0);

        // Multi-press never counts; then a clean single press votes for candidate 1.
        a0 = acc_seen;
        bus.arm = 1'b1; cyc(1); bus.arm = 1'b0;
        bus.button = 4'b0011;
        cyc(10);
        check("multi_still_armed", int'(bus.ready), 1);
        bus.button = 4'b0010;
        cyc(HOLD);
        check("multi_pulse", int'(bus.vote_accepted), 1);
        cyc(FB);
        bus.button = '0;
        cyc(2);
        check("multi_pulses",   acc_seen - a0, 1);
        check("multi_model_c1", m_cnt[1], 1);
        check("multi_winner",   int'(bus.winner_idx), 0);
        check("multi_tie",      int'(bus.tie), 1);

        // Saturation of candidate 2.
        for (int v = 0; v < 7; v++) vote(2);
        check("sat7_model_c2", m_cnt[2], 7);
        check("sat7_winner",   int'(bus.winner_idx), 2);
        check("sat7_tie",      int'(bus.tie), 0);
        check("sat7_ovf",      int'(bus.overflow), 0);
        a0 = acc_seen;
        vote(2);
        check("sat8_pulses",   acc_seen - a0, 1);
        check("sat8_model_c2", m_cnt[2], 7);
        check("sat8_ovf",      int'(bus.overflow), 1);
        check("sat8_winner",   int'(bus.winner_idx), 2);

        // Asynchronous reset in the middle of the acknowledgement.
        bus.arm = 1'b1; cyc(1); bus.arm = 1'b0;
        bus.button = 4'b0001;
        cyc(HOLD);
        #2;
        check("fb_led_pre", int'(bus.led), CMAX);
        reset_n = 1'b0;
        #1;
        check("arst_led",    int'(bus.led),           0);
        check("arst_ready",  int'(bus.ready),         0);
        check("arst_acc",    int'(bus.vote_accepted), 0);
        check("arst_ovf",    int'(bus.overflow),      0);
        check("arst_winner", int'(bus.winner_idx),    0);
        check("arst_tie",    int'(bus.tie),           0);
        bus.button = '0;
        cyc(2);
        reset_n = 1'b1;
        cyc(2);

        // mode=1 while armed cancels the ballot.
        a0 = acc_seen;
        bus.arm = 1'b1; cyc(1); bus.arm = 1'b0;
        bus.button = 4'b0001;
        cyc(2);
        bus.mode = 1'b1;
        cyc(1);
        check("cancel_ready", int'(bus.ready), 0);
        bus.mode = 1'b0;
        cyc(6);
        bus.button = '0;
        cyc(1);
        check("cancel_pulses", acc_seen - a0, 0);

        // Result display with a tie between candidates 1 and 3.
        vote(1);
        vote(3);
        bus.mode = 1'b1;
        bus.button = 4'b1000;
        cyc(1);
        check("disp_led_c3", int'(bus.led),        1);
        check("disp_winner", int'(bus.winner_idx), 1);
        check("disp_tie",    int'(bus.tie),        1);
        bus.button = 4'b0001;
        cyc(1);
        check("disp_led_c0", int'(bus.led), 0);
        bus.arm = 1'b1;
        cyc(2);
        check("disp_arm_ignored", int'(bus.ready), 0);
        bus.arm = 1'b0; bus.mode = 1'b0; bus.button = '0;
        cyc(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
